// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: operand forwarding selects, load-use stall detection and a
// saturating stall counter for a 5-stage in-order pipeline. The module keeps
// its own shadow copy of the register-number fields travelling through
// ID/EX (_p0), EX/MEM (_p1) and MEM/WB (_p2).
module hazard_fwd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ID/EX shadow
  logic [4:0] rs1_p0, rs2_p0, rd_p0;
  logic       regwrite_p0, memread_p0;
  // EX/MEM shadow
  logic [4:0] rd_p1;
  logic       regwrite_p1;
  // MEM/WB shadow
  logic [4:0] rd_p2;
  logic       regwrite_p2;

  logic       idex_load;

  // Youngest older producer wins; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_mem,
    input logic       rw_mem,
    input logic [4:0] rd_wb,
    input logic       rw_wb
  );
    if (rw_mem && (rd_mem != 5'd0) && (rd_mem == rs))
      return FWD_MEM;
    else if (rw_wb && (rd_wb != 5'd0) && (rd_wb == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v)
      return v;
    else
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Hazard detection and forwarding selects, all combinational on the shadows.
  always_comb begin
    forward_a  = fwd_sel(rs1_p0, rd_p1, regwrite_p1, rd_p2, regwrite_p2);
    forward_b  = fwd_sel(rs2_p0, rd_p1, regwrite_p1, rd_p2, regwrite_p2);
    // Flush squashes the consumer anyway, so it overrides the load-use stall.
    stall      = !reset && memread_p0 && (rd_p0 != 5'd0) && id_valid && !flush &&
                 ((rd_p0 == id_rs1) || (rd_p0 == id_rs2));
    pc_write   = !stall;
    ifid_write = !stall;
    idex_load  = id_valid && !stall && !flush;
  end

  // ---- ID -> EX boundary: take the ID instruction or insert a bubble ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_p0      <= 5'd0;
      rs2_p0      <= 5'd0;
      rd_p0       <= 5'd0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
    end else if (idex_load) begin
      rs1_p0      <= id_rs1;
      rs2_p0      <= id_rs2;
      rd_p0       <= id_rd;
      regwrite_p0 <= id_regwrite;
      memread_p0  <= id_memread;
    end else begin
      rs1_p0      <= 5'd0;
      rs2_p0      <= 5'd0;
      rd_p0       <= 5'd0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
    end
  end

  // ---- EX -> MEM -> WB boundaries: unconditional shift of destination info ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1       <= 5'd0;
      regwrite_p1 <= 1'b0;
      rd_p2       <= 5'd0;
      regwrite_p2 <= 1'b0;
    end else begin
      rd_p1       <= rd_p0;
      regwrite_p1 <= regwrite_p0;
      rd_p2       <= rd_p1;
      regwrite_p2 <= regwrite_p1;
    end
  end

  // Count every cycle spent stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall)
      stall_count <= sat_inc(stall_count);
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: directed pipeline scenarios followed by
// random instruction streams, compared against an instruction-level model.
module tb_hazard_fwd_ctrl;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_regwrite, id_memread, flush;
  logic [1:0]       forward_a, forward_b;
  logic             stall, pc_write, ifid_write;
  logic [CNT_W-1:0] stall_count;

  hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // An instruction as it sits in a pipeline stage (bubble = all zero).
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr;
  } ins_t;

  ins_t stg [3];       // 0 = EX, 1 = MEM, 2 = WB
  int   m_count;
  logic m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 0; b.mr = 0;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) stg[i] = bubble();
    m_count = 0;
  endtask

  // Expected operand source: the nearest older in-flight writer of rs.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    for (int s = 1; s <= 2; s++)
      if (stg[s].rw && stg[s].rd == rs) return (s == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Drive ID inputs, let combinational outputs settle, compare with model.
  task automatic apply(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    m_stall = stg[0].mr && stg[0].rd != 0 && v && !fl &&
              (stg[0].rd == r1 || stg[0].rd == r2);
    check("fwd_a", forward_a, exp_fwd(stg[0].rs1));
    check("fwd_b", forward_b, exp_fwd(stg[0].rs2));
    check("stall", stall, m_stall);
    check("pc_write", pc_write, !m_stall);
    check("ifid_write", ifid_write, !m_stall);
    check("stall_count", stall_count, m_count);
  endtask

  // Clock edge: advance model pipeline, then return at the falling edge.
  task automatic tick();
    ins_t n;
    @(posedge clk);
    if (m_stall && m_count < CMAX) m_count++;
    n = bubble();
    if (id_valid && !m_stall && !flush) begin
      n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.rw = id_regwrite; n.mr = id_memread;
    end
    stg[2] = stg[1];
    stg[1] = stg[0];
    stg[0] = n;
    @(negedge clk);
  endtask

  task automatic nop();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; flush = 0;
    model_reset();
    #2;
    check("rst_fa", forward_a, 2'b00);
    check("rst_fb", forward_b, 2'b00);
    check("rst_stall", stall, 1'b0);
    check("rst_pcw", pc_write, 1'b1);
    check("rst_ifidw", ifid_write, 1'b1);
    check("rst_cnt", stall_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // EX/MEM forwarding: add x5 then consumer of x5
    apply(1, 0, 0, 5, 1, 0, 0); tick();
    apply(1, 5, 0, 6, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("exmem_fa", forward_a, 2'b10);
    check("exmem_fb", forward_b, 2'b00);
    tick(); nop(); nop();

    // MEM/WB forwarding: write x7, independent, consumer rs2=7
    apply(1, 0, 0, 7, 1, 0, 0); tick();
    apply(1, 1, 2, 8, 1, 0, 0); tick();
    apply(1, 0, 7, 9, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("memwb_fb", forward_b, 2'b01);
    tick(); nop(); nop();

    // Priority: two writers of x3, newest wins
    apply(1, 0, 0, 3, 1, 0, 0); tick();
    apply(1, 0, 0, 3, 1, 0, 0); tick();
    apply(1, 3, 0, 4, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("prio_fa", forward_a, 2'b10);
    tick();
    // x0 is never forwarded
    apply(1, 0, 0, 0, 1, 0, 0); tick();
    apply(1, 0, 0, 4, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("x0_fa", forward_a, 2'b00);
    tick(); nop(); nop();

    // Load-use: one stall cycle, then forward from MEM/WB
    do_reset();
    apply(1, 0, 0, 9, 1, 1, 0); tick();
    apply(1, 0, 9, 10, 1, 0, 0);
    check("lu_stall", stall, 1'b1);
    check("lu_pcw", pc_write, 1'b0);
    tick();
    apply(1, 0, 9, 10, 1, 0, 0);
    check("lu_stall_once", stall, 1'b0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("lu_fb", forward_b, 2'b01);
    check("lu_cnt", stall_count, 1);
    tick(); nop(); nop();

    // Flush overrides stall; the squashed consumer must not appear in EX
    apply(1, 0, 0, 11, 1, 1, 0); tick();
    apply(1, 11, 0, 12, 1, 0, 1);
    check("fl_stall", stall, 1'b0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    check("fl_bubble_fa", forward_a, 2'b00);
    check("fl_cnt", stall_count, 1);
    tick(); nop(); nop();

    // Saturation at 3 after 5 stalls
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 9, 1, 1, 0); tick();
      apply(1, 9, 0, 1, 1, 0, 0); tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    check("sat_cnt", stall_count, 3);
    tick();

    // Reset mid-stall clears immediately, without a clock edge
    apply(1, 0, 0, 9, 1, 1, 0); tick();
    apply(1, 9, 0, 1, 1, 0, 0);
    check("mid_stall_pre", stall, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_stall", stall, 1'b0);
    check("mid_cnt", stall_count, 0);
    check("mid_pcw", pc_write, 1'b1);
    check("mid_fa", forward_a, 2'b00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random streams over a small register set to provoke hazards
    for (int c = 0; c < 600; c++) begin
      apply(($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  ID-stage source register numbers.
REQ-006 SHALL have port id_rd  input  5  ID-stage destination register.
REQ-007 SHALL have port id_regwrite  input  1  ID-stage instruction writes rd.
REQ-008 SHALL have port id_memread  input  1  ID-stage instruction is a load.
REQ-009 SHALL have port flush  input  1  branch taken; squash the instruction entering EX.
REQ-010 SHALL have ports forward_a, forward_b  output  2 each  EX operand select for the 64-bit 4:1 operand mux (00 regfile, 01 MEM/WB result, 10 EX/MEM result, 11 reserved).
REQ-011 SHALL have port stall  output  1  load-use hazard; hold PC and IF/ID.
REQ-012 SHALL have port pc_write  output  1  PC update enable (= ~stall).
REQ-013 SHALL have port ifid_write  output  1  IF/ID register enable (= ~stall).
REQ-014 SHALL have port stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 SHALL keep internal shadow pipeline registers: ID/EX {rs1, rs2, rd, regwrite, memread}, EX/MEM {rd, regwrite}, MEM/WB {rd, regwrite}, all advancing on every rising clk edge.
REQ-016 SHALL load ID/EX from id_* inputs when id_valid=1, stall=0 and flush=0.
REQ-017 SHALL load ID/EX with a bubble (all fields 0) when stall=1, flush=1 or id_valid=0.
REQ-018 SHALL give flush priority over stall: flush=1 forces stall=0 in the same cycle.
REQ-019 SHALL copy ID/EX rd and regwrite to EX/MEM, and EX/MEM to MEM/WB, every cycle without condition.
REQ-020 SHALL drive forward_a combinationally:
- 10 when EX/MEM regwrite=1, EX/MEM rd!=0 and EX/MEM rd=ID/EX rs1;
- else 01 when MEM/WB regwrite=1, MEM/WB rd!=0 and MEM/WB rd=ID/EX rs1;
- else 00.
REQ-021 SHALL compute forward_b identically using ID/EX rs2.
REQ-022 SHALL never drive 11 on forward_a or forward_b.
REQ-023 SHALL never forward from register x0, even when regwrite=1.
REQ-024 SHALL assert stall combinationally when:
- ID/EX memread=1, ID/EX rd!=0, id_valid=1 and flush=0; and
- ID/EX rd equals id_rs1 or id_rs2.
REQ-025 SHALL produce one stall cycle per load-use hazard, because the bubble clears ID/EX memread on the next edge.
REQ-026 SHALL increment stall_count by 1 on each clock edge where stall=1, saturating at all-ones.

Reset
REQ-027 SHALL clear all shadow registers and stall_count to 0 immediately on reset=1, independent of clk.
REQ-028 SHALL, while reset=1, output forward_a=00, forward_b=00, stall=0, pc_write=1, ifid_write=1 and stall_count=0.
REQ-029 SHALL, on reset asserted mid-stall, deassert stall at once and discard any pending bubble.
REQ-030 SHALL resume normal operation on the first clock edge after reset deasserts.

Verification
REQ-031 SHALL pass this EX/MEM forwarding case: issue add x5 (rd=5, regwrite=1), then next-cycle instruction with rs1=5 -> forward_a=10, forward_b=00 in the cycle the second instruction is in EX.
REQ-032 SHALL pass this MEM/WB forwarding case: write x7, one independent instruction, then rs2=7 -> forward_b=01 when the consumer is in EX.
REQ-033 SHALL pass this priority and x0 case:
- x3 written in two consecutive instructions, then a consumer with rs1=3 -> forward_a=10;
- writer with rd=0, then a consumer with rs1=0 -> forward_a=00.
REQ-034 SHALL pass this load-use case: load rd=9, then consumer with rs2=9 ->
- stall=1, pc_write=0, ifid_write=0 for exactly one cycle;
- a bubble enters EX;
- the consumer then sees forward_b=01;
- stall_count=1.
REQ-035 SHALL pass this flush-over-stall case: load-use condition present with flush=1 -> stall=0 and ID/EX holds a bubble the next cycle.
REQ-036 SHALL pass this saturation-and-reset case:
- CNT_W=2 and 5 stall cycles -> stall_count=3;
- reset asserted mid-stall -> stall=0 and stall_count=0 before the next clk edge.
